hd_program_loader: RTL and testbench

// - Copies one program image from the Hard_Disk ROM into instruction memory when the processor

---
 rtl/hd_loader_pkg.sv | 27 ++
 rtl/hd_read_pipe.sv | 44 ++++
 rtl/hd_program_loader.sv | 198 +++++++++++++++++++
 tb/tb_hd_program_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_loader_pkg.sv
// Shared types and helpers for the HD program loader: FSM states, header
// length field position and the slot base-address calculation.
package hd_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_COPY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Program length lives in the low bits of the slot header word.
  localparam int unsigned HDR_LEN_W   = 11;
  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_MSB = HDR_LEN_LSB + HDR_LEN_W - 1;

  // Base word address of a slot: the low idx_bits of the index placed above
  // slot_bits zeros. Callers truncate the result to their address width.
  function automatic logic [31:0] slot_base(input logic [31:0] idx,
                                            input int unsigned idx_bits,
                                            input int unsigned slot_bits);
    logic [31:0] mask;
    mask = (32'd1 << idx_bits) - 32'd1;
    return (idx & mask) << slot_bits;
  endfunction

endpackage

// File: rtl/hd_read_pipe.sv
// Tag pipeline for HD reads. Each issued read carries a valid bit, a header
// flag and the program word index; the tag emerges LAT cycles later, aligned
// with the matching hd_data word.
module hd_read_pipe #(
  parameter int LAT   = 1,
  parameter int IDX_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_hdr_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             out_valid_o,
  output logic             out_hdr_o,
  output logic [IDX_W-1:0] out_idx_o
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] hdr_q;
  logic [IDX_W-1:0] idx_q [LAT];

  // Shift the read tags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      hdr_q   <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      hdr_q[0]   <= in_hdr_i;
      idx_q[0]   <= in_idx_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        hdr_q[i]   <= hdr_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_hdr_o   = hdr_q[LAT-1];
  assign out_idx_o   = idx_q[LAT-1];

endmodule

// File: rtl/hd_program_loader.sv
// Copies one program image from a Hard_Disk slot into instruction memory.
//
// state   | meaning
// IDLE    | waiting for Load_from_HD
// HDR     | slot header read issued, waiting for the length word
// COPY    | streaming words HD -> RAM, one read per cycle
// DONE    | one-cycle load_done pulse, load_error valid
module hd_program_loader
  import hd_loader_pkg::*;
#(
  parameter int HD_AW        = 12,
  parameter int RAM_AW       = 10,
  parameter int SLOT_WORDS   = 256,
  parameter int NUM_PROGRAMS = 16,
  parameter int HD_LATENCY   = 1,
  parameter int RAM_BASE     = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load_from_HD,
  input  logic [11:0]       indice_programa,
  output logic [HD_AW-1:0]  hd_addr,
  input  logic [31:0]       hd_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              ram_we,
  output logic              carregando,
  output logic              load_done,
  output logic              load_error,
  output logic [10:0]       words_loaded
);

  localparam int unsigned IDX_BITS  = $clog2(NUM_PROGRAMS);
  localparam int unsigned SLOT_BITS = $clog2(SLOT_WORDS);
  localparam int unsigned LEN_W     = HDR_LEN_W;
  localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(SLOT_WORDS - 1);
  localparam logic [RAM_AW-1:0] RAM_BASE_W = RAM_AW'(RAM_BASE);

  state_e            state_q, state_d;
  logic [HD_AW-1:0]  hd_addr_q, hd_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic              hdr_sent_q, hdr_sent_d;
  logic              err_pend_q, err_pend_d;
  logic              err_q, err_d;
  logic [10:0]       wl_q, wl_d;

  logic              iss_valid;
  logic              iss_hdr;
  logic [LEN_W-1:0]  iss_idx;
  logic              rd_valid;
  logic              rd_hdr;
  logic [LEN_W-1:0]  rd_idx;

  logic [LEN_W-1:0]  hdr_len;
  logic              idx_bad;
  logic [HD_AW-1:0]  slot_addr;

  assign hdr_len   = hd_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign idx_bad   = 32'(indice_programa) >= 32'(NUM_PROGRAMS);
  assign slot_addr = HD_AW'(slot_base(32'(indice_programa), IDX_BITS, SLOT_BITS));

  hd_read_pipe #(
    .LAT   (HD_LATENCY),
    .IDX_W (LEN_W)
  ) u_read_pipe (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .in_valid_i  (iss_valid),
    .in_hdr_i    (iss_hdr),
    .in_idx_i    (iss_idx),
    .out_valid_o (rd_valid),
    .out_hdr_o   (rd_hdr),
    .out_idx_o   (rd_idx)
  );

  // Write side is driven purely by returning read tags, so it follows HD_LATENCY.
  assign ram_we       = rd_valid & ~rd_hdr;
  assign ram_addr     = ram_we ? (RAM_BASE_W + RAM_AW'(rd_idx)) : '0;
  assign ram_data     = ram_we ? hd_data : '0;
  assign hd_addr      = hd_addr_q;
  assign carregando   = (state_q == ST_HDR) || (state_q == ST_COPY);
  assign load_done    = (state_q == ST_DONE);
  assign load_error   = err_q;
  assign words_loaded = wl_q;

  // Next-state, read issue and bookkeeping for the load sequence.
  always_comb begin
    state_d    = state_q;
    hd_addr_d  = hd_addr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    k_d        = k_q;
    hdr_sent_d = hdr_sent_q;
    err_pend_d = err_pend_q;
    err_d      = err_q;
    wl_d       = wl_q;
    iss_valid  = 1'b0;
    iss_hdr    = 1'b0;
    iss_idx    = k_q;

    if (ram_we) wl_d = wl_q + 11'd1;

    case (state_q)
      ST_IDLE: begin
        if (Load_from_HD) begin
          err_d      = 1'b0;
          err_pend_d = 1'b0;
          hdr_sent_d = 1'b0;
          wl_d       = '0;
          if (idx_bad) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_HDR;
            hd_addr_d = slot_addr;
          end
        end
      end

      ST_HDR: begin
        if (!hdr_sent_q) begin
          iss_valid  = 1'b1;
          iss_hdr    = 1'b1;
          hdr_sent_d = 1'b1;
        end
        if (rd_valid && rd_hdr) begin
          if (hdr_len == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_COPY;
            hd_addr_d = hd_addr_q + HD_AW'(1);
            k_d       = '0;
            // Oversized headers still copy a full slot, but flag the truncation.
            if (hdr_len > MAX_LEN) begin
              len_d      = MAX_LEN;
              rem_d      = MAX_LEN;
              err_pend_d = 1'b1;
            end else begin
              len_d = hdr_len;
              rem_d = hdr_len;
            end
          end
        end
      end

      ST_COPY: begin
        if (rem_q != '0) begin
          iss_valid = 1'b1;
          rem_d     = rem_q - LEN_W'(1);
          k_d       = k_q + LEN_W'(1);
          // Leave hd_addr on the final word once the last read is out.
          if (rem_q != LEN_W'(1)) hd_addr_d = hd_addr_q + HD_AW'(1);
        end
        if (rd_valid && !rd_hdr && (rd_idx == (len_q - LEN_W'(1)))) begin
          state_d = ST_DONE;
          err_d   = err_pend_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      hd_addr_q  <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      k_q        <= '0;
      hdr_sent_q <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
      wl_q       <= '0;
    end else begin
      state_q    <= state_d;
      hd_addr_q  <= hd_addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      k_q        <= k_d;
      hdr_sent_q <= hdr_sent_d;
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
    end
  end

endmodule

// File: tb/tb_hd_program_loader.sv
// Bench for hd_program_loader: two instances (HD latency 1 and 2, different
// RAM bases) share the request inputs; each sees its own delayed HD ROM view.
module tb_hd_program_loader;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] indice;

  logic [11:0] hd_addr      [NI];
  logic [31:0] hd_data      [NI];
  logic [9:0]  ram_addr     [NI];
  logic [31:0] ram_data     [NI];
  logic        ram_we       [NI];
  logic        carregando   [NI];
  logic        load_done    [NI];
  logic        load_error   [NI];
  logic [10:0] words_loaded [NI];

  logic [31:0] hd_mem [4096];
  logic [11:0] a_d1 [NI];
  logic [11:0] a_d2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // request description, written only by the stimulus process
  int req_T = -10;
  int req_base = 0;
  int req_n = 0;
  bit req_bad = 1'b0;

  // observations, written only by the monitor
  int   wr_cnt [NI];
  int   wr_bad [NI];
  int   last_addr [NI];
  int   done_cnt [NI];
  int   done_cyc [NI];
  logic done_err [NI];
  logic [10:0] done_wl [NI];
  int   car_cnt [NI];
  int   car_first [NI];
  int   car_last [NI];
  int   hda_bad [NI];

  function automatic int lat_of(input int i);
    return i + 1;
  endfunction

  function automatic int rbase_of(input int i);
    return (i == 0) ? 0 : 1000;
  endfunction

  hd_program_loader #(.HD_LATENCY(1), .RAM_BASE(0)) u_l1 (
    .Clock(clk), .Reset(rst), .Load_from_HD(load), .indice_programa(indice),
    .hd_addr(hd_addr[0]), .hd_data(hd_data[0]), .ram_addr(ram_addr[0]),
    .ram_data(ram_data[0]), .ram_we(ram_we[0]), .carregando(carregando[0]),
    .load_done(load_done[0]), .load_error(load_error[0]), .words_loaded(words_loaded[0])
  );

  hd_program_loader #(.HD_LATENCY(2), .RAM_BASE(1000)) u_l2 (
    .Clock(clk), .Reset(rst), .Load_from_HD(load), .indice_programa(indice),
    .hd_addr(hd_addr[1]), .hd_data(hd_data[1]), .ram_addr(ram_addr[1]),
    .ram_data(ram_data[1]), .ram_we(ram_we[1]), .carregando(carregando[1]),
    .load_done(load_done[1]), .load_error(load_error[1]), .words_loaded(words_loaded[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // HD ROM with 1- and 2-cycle read latency
  always @(posedge clk) begin
    a_d1[0] <= hd_addr[0];
    a_d1[1] <= hd_addr[1];
    a_d2    <= a_d1[1];
  end
  assign hd_data[0] = hd_mem[a_d1[0]];
  assign hd_data[1] = hd_mem[a_d2];

  // Monitor: log activity of the current request and compare every RAM write
  // and HD address against the timing formula.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int lat;
      int k;
      int rel;
      lat = lat_of(i);
      if (cyc == req_T + 1) begin
        wr_cnt[i] = 0; wr_bad[i] = 0; last_addr[i] = -1;
        done_cnt[i] = 0; done_cyc[i] = -1; done_err[i] = 1'b0; done_wl[i] = '0;
        car_cnt[i] = 0; car_first[i] = -1; car_last[i] = -1; hda_bad[i] = 0;
      end
      if (req_T >= 0 && cyc > req_T) begin
        if (ram_we[i]) begin
          k = wr_cnt[i];
          if (k >= req_n || cyc != req_T + 2 + 2*lat + k ||
              int'(ram_addr[i]) != (rbase_of(i) + k) % 1024 ||
              ram_data[i] !== hd_mem[req_base + 1 + k])
            wr_bad[i]++;
          last_addr[i] = int'(ram_addr[i]);
          wr_cnt[i]++;
        end
        if (load_done[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
          done_err[i] = load_error[i];
          done_wl[i]  = words_loaded[i];
        end
        if (carregando[i]) begin
          if (car_cnt[i] == 0) car_first[i] = cyc;
          car_last[i] = cyc;
          car_cnt[i]++;
        end
        if (!req_bad) begin
          if (cyc == req_T + 1 && int'(hd_addr[i]) != req_base) hda_bad[i]++;
          rel = cyc - (req_T + 2 + lat);
          if (rel >= 0 && rel < req_n && int'(hd_addr[i]) != req_base + 1 + rel) hda_bad[i]++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_slot(input int idx, input int len);
    int base;
    base = idx * 256;
    hd_mem[base] = ($urandom & 32'hFFFF_F800) | (len & 32'h7FF);
    for (int w = 1; w < 256; w++) hd_mem[base + w] = $urandom;
  endtask

  task automatic run_load(input int idx, input int len, input bit extra);
    int  t0, n, lat, exp_done, exp_last;
    bit  bad, zero, err;
    string s;
    bad  = (idx >= 16);
    zero = (len == 0);
    n    = (bad || zero) ? 0 : ((len > 255) ? 255 : len);
    err  = bad || zero || (len > 255);
    if (!bad) fill_slot(idx, len);
    @(negedge clk);
    t0 = cyc;
    req_T = t0; req_base = bad ? 0 : idx * 256; req_n = n; req_bad = bad;
    load = 1'b1; indice = 12'(idx);
    @(negedge clk);
    load = 1'b0; indice = 12'($urandom);
    for (int c = 0; c < 320; c++) begin
      if (extra && cyc == t0 + 5) begin load = 1'b1; indice = 12'd3; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lat = lat_of(i);
      exp_done = bad ? t0 + 1 : (zero ? t0 + 2 + lat : t0 + 2 + 2*lat + n);
      exp_last = zero ? t0 + 1 + lat : t0 + 1 + 2*lat + n;
      s = $sformatf("idx%0d len%0d L%0d", idx, len, lat);
      chk({s, " done_cnt"}, 32'(done_cnt[i]), 32'(1));
      chk({s, " done_cyc"}, 32'(done_cyc[i] - t0), 32'(exp_done - t0));
      chk({s, " done_err"}, 32'(done_err[i]), 32'(err));
      chk({s, " done_wl"}, 32'(done_wl[i]), 32'(n));
      chk({s, " wr_cnt"}, 32'(wr_cnt[i]), 32'(n));
      chk({s, " wr_bad"}, 32'(wr_bad[i]), 32'(0));
      chk({s, " hda_bad"}, 32'(hda_bad[i]), 32'(0));
      chk({s, " car_cnt"}, 32'(car_cnt[i]), 32'(bad ? 0 : exp_last - t0));
      if (!bad) begin
        chk({s, " car_first"}, 32'(car_first[i] - t0), 32'(1));
        chk({s, " car_last"}, 32'(car_last[i] - t0), 32'(exp_last - t0));
      end
      chk({s, " err_hold"}, 32'(load_error[i]), 32'(err));
      chk({s, " wl_hold"}, 32'(words_loaded[i]), 32'(n));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s hd_addr u%0d", tag, i), 32'(hd_addr[i]), 32'(0));
      chk($sformatf("%s ram_addr u%0d", tag, i), 32'(ram_addr[i]), 32'(0));
      chk($sformatf("%s ram_data u%0d", tag, i), ram_data[i], 32'(0));
      chk($sformatf("%s ram_we u%0d", tag, i), 32'(ram_we[i]), 32'(0));
      chk($sformatf("%s carregando u%0d", tag, i), 32'(carregando[i]), 32'(0));
      chk($sformatf("%s load_done u%0d", tag, i), 32'(load_done[i]), 32'(0));
      chk($sformatf("%s load_error u%0d", tag, i), 32'(load_error[i]), 32'(0));
      chk($sformatf("%s words_loaded u%0d", tag, i), 32'(words_loaded[i]), 32'(0));
    end
  endtask

  initial begin
    int t0;
    int idx, cls, len;
    rst = 1'b1; load = 1'b0; indice = '0;
    for (int a = 0; a < 4096; a++) hd_mem[a] = $urandom;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // directed cases
    run_load(2, 3, 1'b1);
    run_load(20, 5, 1'b0);
    run_load(7, 0, 1'b0);
    run_load(15, 400, 1'b0);
    chk("len400 last ram addr u0", 32'(last_addr[0]), 32'(254));
    chk("len400 last ram addr u1", 32'(last_addr[1]), 32'((1000 + 254) % 1024));

    // reset in the middle of COPY
    fill_slot(5, 50);
    @(negedge clk);
    t0 = cyc;
    req_T = t0; req_base = 5 * 256; req_n = 50; req_bad = 1'b0;
    load = 1'b1; indice = 12'd5;
    @(negedge clk);
    load = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort");
    rst = 1'b0;
    repeat (300) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("abort done_cnt u%0d", i), 32'(done_cnt[i]), 32'(0));
      chk($sformatf("abort car_last u%0d", i), 32'(car_last[i] - t0), 32'(10));
    end

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      idx = $urandom_range(0, 19);
      cls = $urandom_range(0, 3);
      case (cls)
        0: len = $urandom_range(1, 12);
        1: len = 255;
        2: len = 256 + $urandom_range(0, 1791);
        default: len = $urandom_range(0, 60);
      endcase
      run_load(idx, len, r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
